// File: rtl/floo_axis_link_scheduler.sv
// Request/response flit scheduler onto one shared AXIS link with burst-limited fairness.
// Define FLOO_AXIS_SCHED_STATS_EN to compile in the per-class beat counters.
module floo_axis_link_scheduler #(
    parameter int unsigned ReqWidth = 64,
    parameter int unsigned RspWidth = 48,
    parameter int unsigned MaxBurst = 4,
    localparam int unsigned DataWidth = (ReqWidth > RspWidth) ? ReqWidth : RspWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ReqWidth-1:0]  req_data_i,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [RspWidth-1:0]  rsp_data_i,
    output logic                 axis_tvalid_o,
    input  logic                 axis_tready_i,
    output logic [DataWidth:0]   axis_tdata_o,
    output logic [31:0]          cnt_req_o,
    output logic [31:0]          cnt_rsp_o
);

    typedef enum logic [1:0] {
        IDLE,
        OWN_REQ,
        OWN_RSP
    } state_e;

    localparam logic [7:0] MaxCnt = 8'(MaxBurst);

    state_e               state;
    logic [7:0]           burst_cnt;
    logic [7:0]           cnt_inc;
    logic                 out_valid;
    logic [DataWidth:0]   out_data;
    logic                 load_en;
    logic                 sel_req;
    logic                 sel_rsp;
    logic [DataWidth-1:0] req_pad;
    logic [DataWidth-1:0] rsp_pad;

    assign req_pad = DataWidth'(req_data_i);
    assign rsp_pad = DataWidth'(rsp_data_i);
    assign load_en = !out_valid || axis_tready_i;
    assign cnt_inc = (burst_cnt >= MaxCnt) ? MaxCnt : burst_cnt + 8'd1;

    always_comb begin
        sel_req = 1'b0;
        sel_rsp = 1'b0;
        case (state)
            OWN_REQ: begin
                if (req_valid_i && (burst_cnt < MaxCnt || !rsp_valid_i)) sel_req = 1'b1;
                else if (rsp_valid_i) sel_rsp = 1'b1;
            end
            OWN_RSP: begin
                if (rsp_valid_i && (burst_cnt < MaxCnt || !req_valid_i)) sel_rsp = 1'b1;
                else if (req_valid_i) sel_req = 1'b1;
            end
            // Responses win ties so the link keeps draining
            default: begin
                if (rsp_valid_i) sel_rsp = 1'b1;
                else if (req_valid_i) sel_req = 1'b1;
            end
        endcase
    end

    assign req_ready_o   = sel_req && load_en && !rst_i;
    assign rsp_ready_o   = sel_rsp && load_en && !rst_i;
    assign axis_tvalid_o = out_valid && !rst_i;
    assign axis_tdata_o  = out_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load_en) begin
            out_valid <= sel_req || sel_rsp;
            if (sel_rsp) begin
                out_data  <= {1'b1, rsp_pad};
                state     <= OWN_RSP;
                burst_cnt <= (state == OWN_RSP) ? cnt_inc : 8'd1;
            end else if (sel_req) begin
                out_data  <= {1'b0, req_pad};
                state     <= OWN_REQ;
                burst_cnt <= (state == OWN_REQ) ? cnt_inc : 8'd1;
            end else begin
                state     <= IDLE;
                burst_cnt <= '0;
            end
        end
    end

`ifdef FLOO_AXIS_SCHED_STATS_EN
    logic [31:0] cnt_req_q;
    logic [31:0] cnt_rsp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_req_q <= '0;
            cnt_rsp_q <= '0;
        end else if (out_valid && axis_tready_i) begin
            if (out_data[DataWidth]) cnt_rsp_q <= cnt_rsp_q + 32'd1;
            else cnt_req_q <= cnt_req_q + 32'd1;
        end
    end

    assign cnt_req_o = cnt_req_q;
    assign cnt_rsp_o = cnt_rsp_q;
`else
    assign cnt_req_o = '0;
    assign cnt_rsp_o = '0;
`endif

endmodule

// File: tb/tb_floo_axis_link_scheduler.sv
// Scoreboard bench for floo_axis_link_scheduler: arbitration order, stalls,
// reset discard, zero-extension and beat statistics.
module tb_floo_axis_link_scheduler;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [63:0]   req_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [47:0]   rsp_data;
    logic          axis_tvalid;
    logic          axis_tready;
    logic [DW:0]   axis_tdata;
    logic [31:0]   cnt_req;
    logic [31:0]   cnt_rsp;

    logic [63:0]   req_src[$];
    logic [47:0]   rsp_src[$];
    logic [DW:0]   exp_q[$];

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            ph_first = -1;
    int            ph_last = -1;
    logic          req_fire = 1'b0;
    logic          rsp_fire = 1'b0;

    floo_axis_link_scheduler #(
        .ReqWidth (64),
        .RspWidth (48),
        .MaxBurst (4)
    ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_data_i    (req_data),
        .rsp_valid_i   (rsp_valid),
        .rsp_ready_o   (rsp_ready),
        .rsp_data_i    (rsp_data),
        .axis_tvalid_o (axis_tvalid),
        .axis_tready_i (axis_tready),
        .axis_tdata_o  (axis_tdata),
        .cnt_req_o     (cnt_req),
        .cnt_rsp_o     (cnt_rsp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Source: presents queue heads, pops on the handshake seen before the edge
    initial begin
        req_valid = 1'b0;
        req_data  = '0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (req_fire) void'(req_src.pop_front());
            if (rsp_fire) void'(rsp_src.pop_front());
            req_valid = req_src.size() != 0;
            req_data  = req_valid ? req_src[0] : '0;
            rsp_valid = rsp_src.size() != 0;
            rsp_data  = rsp_valid ? rsp_src[0] : '0;
        end
    end

    // Monitor: inputs are stable at the falling edge
    initial begin
        logic [DW:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            req_fire = req_valid && req_ready;
            rsp_fire = rsp_valid && rsp_ready;
            if (!rst && axis_tvalid && axis_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", axis_tdata, e);
                end
                if (ph_first < 0) ph_first = cyc;
                ph_last = cyc;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || req_src.size() != 0 || rsp_src.size() != 0) && n < 200) begin
            step(1);
            n++;
        end
        step(2);
        chk({"drain_", nm}, 65'(exp_q.size()), 65'd0);
    endtask

    initial begin
        rst = 1'b1;
        axis_tready = 1'b0;
        step(3);

        // reset state
        @(negedge clk);
        chk("rst_tvalid", 65'(axis_tvalid), 65'd0);
        chk("rst_readies", 65'({req_ready, rsp_ready}), 65'd0);
        chk("rst_tdata", axis_tdata, 65'd0);
        chk("rst_cnt_req", 65'(cnt_req), 65'd0);
        chk("rst_cnt_rsp", 65'(cnt_rsp), 65'd0);
        step(1);
        rst = 1'b0;
        axis_tready = 1'b1;
        step(1);

        // rsp zero-extension, hdr=1
        rsp_src.push_back(48'h0000_0000_ABCD);
        exp_q.push_back({1'b1, 64'h0000_0000_0000_ABCD});
        drain("zext");

        // both valid: four rsp, four req, four rsp, four req with no gap
        ph_first = -1;
        for (int i = 0; i < 8; i++) begin
            req_src.push_back(64'h100 + 64'(i));
            rsp_src.push_back(48'h200 + 48'(i));
        end
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 64'h200 + 64'(i)});
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 64'h100 + 64'(i)});
        for (int i = 4; i < 8; i++) exp_q.push_back({1'b1, 64'h200 + 64'(i)});
        for (int i = 4; i < 8; i++) exp_q.push_back({1'b0, 64'h100 + 64'(i)});
        drain("alt");
        chk("alt_no_bubble", 65'(ph_last - ph_first), 65'd15);

        // req only: ten back-to-back beats
        ph_first = -1;
        for (int i = 0; i < 10; i++) begin
            req_src.push_back(64'hF000_0000_0000_0000 + 64'(i));
            exp_q.push_back({1'b0, 64'hF000_0000_0000_0000 + 64'(i)});
        end
        drain("req_run");
        chk("req_no_bubble", 65'(ph_last - ph_first), 65'd9);

        // stall: held beat stays stable, readies low despite pending req
        axis_tready = 1'b0;
        req_src.push_back(64'h1234);
        req_src.push_back(64'h5678);
        exp_q.push_back({1'b0, 64'h1234});
        exp_q.push_back({1'b0, 64'h5678});
        step(3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_tvalid", 65'(axis_tvalid), 65'd1);
            chk("stall_tdata", axis_tdata, {1'b0, 64'h1234});
            chk("stall_readies", 65'({req_ready, rsp_ready}), 65'd0);
        end
        step(1);
        axis_tready = 1'b1;
        drain("stall");

        // reset with a held beat: beat is dropped
        axis_tready = 1'b0;
        req_src.push_back(64'h5555);
        step(4);
        @(negedge clk);
        chk("pre_rst_tvalid", 65'(axis_tvalid), 65'd1);
        step(1);
        rst = 1'b1;
        step(1);
        @(negedge clk);
        chk("in_rst_tvalid", 65'(axis_tvalid), 65'd0);
        step(1);
        rst = 1'b0;
        axis_tready = 1'b1;
        step(1);
        @(negedge clk);
        chk("post_rst_tvalid", 65'(axis_tvalid), 65'd0);
        step(3);

        // first grant after reset follows the idle rule
        req_src.push_back(64'hAAAA);
        rsp_src.push_back(48'hBBBB);
        exp_q.push_back({1'b1, 64'hBBBB});
        exp_q.push_back({1'b0, 64'hAAAA});
        drain("post_rst");

        // statistics: 7 req and 3 rsp
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 7; i++) req_src.push_back(64'h700 + 64'(i));
        for (int i = 0; i < 3; i++) rsp_src.push_back(48'h30 + 48'(i));
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 64'h30 + 64'(i)});
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 64'h700 + 64'(i)});
        drain("stats");
        @(negedge clk);
`ifdef FLOO_AXIS_SCHED_STATS_EN
        chk("cnt_req", 65'(cnt_req), 65'd7);
        chk("cnt_rsp", 65'(cnt_rsp), 65'd3);
`else
        chk("cnt_req", 65'(cnt_req), 65'd0);
        chk("cnt_rsp", 65'(cnt_rsp), 65'd0);
`endif

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
